// File: rtl/bin_to_bcd.sv
// bin_to_bcd
//   Sequential 10-bit binary to 3-digit packed BCD converter. It uses
//   double-dabble (add-3 then shift) and processes one binary bit per clock.
//   The registered outputs change only on the done pulse, so the downstream
//   display never sees intermediate values.
//
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous, active-high reset
//     start  in   conversion request, sampled only in IDLE
//     bin    in   [9:0] operand, captured on the accepting edge
//     busy   out  high while a conversion is in flight
//     done   out  one-cycle pulse; bcd/ovf update on the same edge
//     bcd    out  [11:8] hundreds, [7:4] tens, [3:0] ones
//     ovf    out  captured operand was > 999; held until the next done
//
//   Build option:
//     BIN2BCD_SAT_EN  when defined, results above 999 saturate to 12'h999.
//                     When undefined, bcd is the value mod 1000.
//   The latency and handshake are identical in both builds.

// Single BCD digit correction: a digit >= 5 would become >= 10 after the
// following doubling, so 3 is added first to make it carry into the next
// nibble.
module bin_to_bcd_digit (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

module bin_to_bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic        ovf
);
  localparam int NUM_DIG = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, FIX} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [15:0]               scr_q, scr_d;    // thousands/hundreds/tens/ones
  logic [9:0]                sreg_q, sreg_d;  // binary bits still to shift in
  logic [11:0]               bcd_q, bcd_d;
  logic                      ovf_q, ovf_d;
  logic                      done_q, done_d;
  logic [NUM_DIG-1:0][3:0]   adj;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    bin_to_bcd_digit u_dig (
      .d_i (scr_q[g*4 +: 4]),
      .d_o (adj[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scr_d   = scr_q;
    sreg_d  = sreg_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d  = bin;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, sreg_d} = {adj, sreg_q} << 1;
        if (cnt_q == 4'd9) state_d = FIX;
        else               cnt_d   = cnt_q + 4'd1;
      end
      FIX: begin
        // A 10-bit value tops out at 1023, so a nonzero thousands digit is
        // the only way to exceed 999.
        ovf_d = (scr_q[15:12] != 4'd0);
`ifdef BIN2BCD_SAT_EN
        bcd_d = (scr_q[15:12] != 4'd0) ? 12'h999 : scr_q[11:0];
`else
        bcd_d = scr_q[11:0];
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scr_q   <= '0;
      sreg_q  <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scr_q   <= scr_d;
      sreg_q  <= sreg_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
endmodule

// File: doc/bin_to_bcd.md
# bin_to_bcd

Sequential binary-to-BCD converter that turns a 10-bit unsigned binary value into three packed BCD digits. It uses iterative double-dabble (shift-and-add-3), processing one bit per clock. It sits directly upstream of the seven-segment display driver and feeds its 12-bit `bcd` input. Its registered output changes only on completion pulses, so the display never shows intermediate values.

## Interface
- No parameters. Widths are fixed: 10-bit binary in, 12-bit BCD out.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a conversion of `bin`; sampled only in IDLE.
- `bin`  in  10  unsigned binary operand, range 0..1023; captured on the accepting edge.
- `busy`  out  1  high while a conversion is in progress (state != IDLE).
- `done`  out  1  one-cycle pulse; `bcd`/`ovf` updated on the same edge.
- `bcd`  out  12  `[11:8]` hundreds, `[7:4]` tens, `[3:0]` ones; each nibble 0..9.
- `ovf`  out  1  set when the captured `bin` > 999; valid with `done`, held until the next `done`.

## Operation
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd`=12'h000, `ovf`=0, iteration counter 0, internal shift register 0.
- Internal working register: 16-bit BCD scratch (4 digits: thousands, hundreds, tens, ones) plus a 10-bit binary shift register. Iteration counter is 4 bits, 0..9.
- State machine:
  - IDLE: on `start`=1, load `bin` into the shift register, clear the scratch, clear the counter, and go to SHIFT. If `start`=0, stay in IDLE.
  - SHIFT: each cycle, add 3 to every scratch digit >= 5, then shift {scratch, binreg} left by 1. After the iteration with counter==9, go to FIX; otherwise increment the counter.
  - FIX: register the final `bcd` and `ovf`, pulse `done`, and go to IDLE.
- FIX output rule: `ovf` = (thousands digit != 0) OR (hundreds digit > 9 is impossible); in practice `ovf` = thousands != 0. The `bcd` value depends on the macro (see Configuration).
- `start` in SHIFT or FIX is ignored and not queued.
- `bin` changes after the accepting edge have no effect on the result in flight.
- `bcd` and `ovf` hold their last values while a new conversion runs.
- Reset mid-conversion aborts immediately: all outputs return to reset values and no `done` is issued.

## Timing
- Edge k: `start` accepted in IDLE. `busy`=1 from after edge k.
- Edges k+1 .. k+10: the 10 SHIFT iterations. Edge k+10 moves to FIX.
- Edge k+11: `bcd` and `ovf` updated, `done`=1 for exactly the cycle after k+11, `busy`=0, state IDLE.
- Latency from `start` edge to valid `bcd`: 11 cycles. Minimum issue interval: 12 cycles.
  - A `start` held high during the `done` cycle is accepted at edge k+12.
- `start` held continuously high gives back-to-back conversions every 12 cycles.

## Configuration
- `BIN2BCD_SAT_EN` defined:
  - When the captured value exceeds 999, `bcd` = 12'h999 (saturated) and `ovf`=1.
  - Otherwise `bcd` = low three digits and `ovf`=0.
- `BIN2BCD_SAT_EN` undefined:
  - `bcd` is always the low three digits (value mod 1000); the thousands digit is dropped.
  - `ovf` still reports value > 999.
- Latency and handshake are identical in both builds.

## Test plan
- Reset, then `start` with `bin`=0 -> `done` at cycle 11 after the accept, `bcd`=12'h000, `ovf`=0; `busy` high for exactly 11 cycles.
- `bin`=999 -> `bcd`=12'h999, `ovf`=0. `bin`=255 -> 12'h255. `bin`=100 -> 12'h100. `bin`=9 -> 12'h009.
- `bin`=1023 -> with `BIN2BCD_SAT_EN`: `bcd`=12'h999, `ovf`=1. Without: `bcd`=12'h023, `ovf`=1. Repeat with `bin`=1000: saturated build gives 12'h999; non-saturated build gives 12'h000; `ovf`=1 in both.
- Start `bin`=512, pulse `start` with `bin`=7 at cycle 5 -> second start ignored, single `done` with `bcd`=12'h512; `bcd` unchanged (previous value) until that `done`.
- Start `bin`=300, assert `reset` at cycle 6 -> `busy`/`done`/`bcd`/`ovf` go to 0 immediately, no `done` follows; the next `start` with `bin`=42 yields 12'h042 after 11 cycles.
- `start` held high with `bin`=123 then 456 -> `done` pulses 12 cycles apart with 12'h123 then 12'h456; `done` never high for two consecutive cycles.
